// File: rtl/spi_cmd_dispatcher_pkg.sv
// Shared definitions for the SPI command dispatcher.
// Holds the command numbers, the reply read-select codes and the bit
// positions of the status reply byte.
package spi_cmd_dispatcher_pkg;

    // Command numbers carried on commAdr
    localparam logic [2:0] CMD_NOP      = 3'd0;
    localparam logic [2:0] CMD_LED_SET  = 3'd1;
    localparam logic [2:0] CMD_LED_CLR  = 3'd2;
    localparam logic [2:0] CMD_BRIGHT   = 3'd3;
    localparam logic [2:0] CMD_BEEP     = 3'd4;
    localparam logic [2:0] CMD_READ_SEL = 3'd5;
    localparam logic [2:0] CMD_KEY_CLR  = 3'd6;
    localparam logic [2:0] CMD_RSVD     = 3'd7;

    // Reply byte sources
    localparam logic [1:0] RSEL_STATUS = 2'd0;
    localparam logic [1:0] RSEL_VER    = 2'd1;
    localparam logic [1:0] RSEL_KEYS   = 2'd2;
    localparam logic [1:0] RSEL_LED    = 2'd3;

    // Status byte layout: {cmdCount[3:0], errFlag, beepOut, |keyLatch, 1}
    localparam int STAT_ONE     = 0;
    localparam int STAT_KEY_ANY = 1;
    localparam int STAT_BEEP    = 2;
    localparam int STAT_ERR     = 3;
    localparam int STAT_CNT_LSB = 4;

    function automatic logic [7:0] status_byte(input logic [3:0] cnt,
                                               input logic       err,
                                               input logic       beep,
                                               input logic       key_any);
        logic [7:0] s;
        s                       = 8'h00;
        s[STAT_ONE]             = 1'b1;
        s[STAT_KEY_ANY]         = key_any;
        s[STAT_BEEP]            = beep;
        s[STAT_ERR]             = err;
        s[STAT_CNT_LSB +: 4]    = cnt;
        return s;
    endfunction

endpackage

// File: rtl/spi_cmd_dispatcher_key_debounce.sv
// Single-key debouncer.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   key_in    - raw asynchronous key level (active-high)
//   rise_o    - high in the cycle the accepted level goes 0->1 (combinational
//               from this block's registers, consumed at the next clk edge)
// The raw key is brought in through a 2-flop synchroniser. A counter restarts
// on any change of the synced level; once the level has held for DEB_TICKS
// cycles it becomes the accepted (stable) level.
module key_debounce
    import spi_cmd_dispatcher_pkg::*;
#(
    parameter logic [15:0] DEB_TICKS = 16'd10000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic rise_o
);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        prev_q,  prev_d;
    logic [15:0] cnt_q,   cnt_d;
    logic        stable_q, stable_d;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        sync1_d  = key_in;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q != prev_q) begin
            cnt_d = 16'd0;
        end else if (cnt_q != DEB_TICKS - 16'd1) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            // Counter saturates here; the level has been stable long enough.
            stable_d = sync2_q;
        end
    end

    assign rise_o = stable_d & ~stable_q;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            cnt_q    <= 16'd0;
            stable_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

endmodule

// File: rtl/spi_cmd_dispatcher.sv
// Command dispatcher behind the SPI slave frame receiver.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   commReady  - command-ready strobe from the receiver (sck domain)
//   commAdr    - 3-bit command number, stable while commReady is high
//   commData   - 8-bit command code, stable while commReady is high
//   sel        - SPI chip select, active-low, asynchronous
//   keys       - raw key inputs, active-high, asynchronous
//   replyData  - byte shifted out by the receiver in the next frame
//   ledOut     - PWM-gated LED drives
//   beepOut    - buzzer enable
//   cmdStrb    - one-clk pulse per executed command
// A rising edge of the synchronised commReady executes the command directly
// from commAdr/commData; those stay stable until the next frame starts.
module spi_cmd_dispatcher
    import spi_cmd_dispatcher_pkg::*;
#(
    parameter int          KEY_NUM   = 8,
    parameter logic [15:0] DEB_TICKS = 16'd10000,
    parameter logic [7:0]  PWM_DIV   = 8'd4,
    parameter logic [15:0] BEEP_UNIT = 16'd50000,
    parameter logic [7:0]  CPLD_VER  = 8'h11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               commReady,
    input  logic [2:0]         commAdr,
    input  logic [7:0]         commData,
    input  logic               sel,
    input  logic [KEY_NUM-1:0] keys,
    output logic [7:0]         replyData,
    output logic [7:0]         ledOut,
    output logic               beepOut,
    output logic               cmdStrb
);

    logic               rdy_s1_q, rdy_s1_d, rdy_s2_q, rdy_s2_d, rdy_s3_q, rdy_s3_d;
    logic               sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
    logic [7:0]         led_reg_q, led_reg_d;
    logic [7:0]         duty_q, duty_d;
    logic [23:0]        beep_cnt_q, beep_cnt_d;
    logic [1:0]         reply_sel_q, reply_sel_d;
    logic [KEY_NUM-1:0] key_latch_q, key_latch_d;
    logic               err_flag_q, err_flag_d;
    logic [3:0]         cmd_count_q, cmd_count_d;
    logic [7:0]         pre_q, pre_d;
    logic [7:0]         pwm_cnt_q, pwm_cnt_d;
    logic [7:0]         led_out_q, led_out_d;
    logic               beep_out_q, beep_out_d;
    logic               cmd_strb_q, cmd_strb_d;
    logic [7:0]         reply_data_q, reply_data_d;

    logic               cmd_fire;
    logic [KEY_NUM-1:0] key_rise;
    logic [KEY_NUM-1:0] key_clr;
    logic [7:0]         reply_mux;

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_deb
        key_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
            .clk    (clk),
            .rst    (rst),
            .key_in (keys[i]),
            .rise_o (key_rise[i])
        );
    end

    always_comb begin
        rdy_s1_d = commReady;
        rdy_s2_d = rdy_s1_q;
        rdy_s3_d = rdy_s2_q;
        sel_s1_d = sel;
        sel_s2_d = sel_s1_q;
        cmd_fire = rdy_s2_q & ~rdy_s3_q;

        led_reg_d   = led_reg_q;
        duty_d      = duty_q;
        beep_cnt_d  = (beep_cnt_q != 24'd0) ? beep_cnt_q - 24'd1 : beep_cnt_q;
        reply_sel_d = reply_sel_q;
        err_flag_d  = err_flag_q;
        cmd_count_d = cmd_count_q;
        key_clr     = '0;

        if (cmd_fire) begin
            cmd_count_d = cmd_count_q + 4'd1;
            case (commAdr)
                CMD_LED_SET:  led_reg_d   = led_reg_q | commData;
                CMD_LED_CLR:  led_reg_d   = led_reg_q & ~commData;
                CMD_BRIGHT:   duty_d      = commData;
                // A new BEEP overrides the running decrement, including 0.
                CMD_BEEP:     beep_cnt_d  = 24'(commData) * 24'(BEEP_UNIT);
                CMD_READ_SEL: reply_sel_d = commData[1:0];
                CMD_KEY_CLR:  key_clr     = commData[KEY_NUM-1:0];
                CMD_RSVD:     err_flag_d  = 1'b1;
                default:      ;
            endcase
        end

        // A new press wins over a clear landing in the same cycle.
        key_latch_d = (key_latch_q & ~key_clr) | key_rise;

        pre_d     = pre_q + 8'd1;
        pwm_cnt_d = pwm_cnt_q;
        if (pre_q == PWM_DIV - 8'd1) begin
            pre_d     = 8'd0;
            pwm_cnt_d = pwm_cnt_q + 8'd1;
        end

        led_out_d  = (pwm_cnt_q < duty_q) ? led_reg_q : 8'h00;
        beep_out_d = (beep_cnt_q != 24'd0);
        cmd_strb_d = cmd_fire;

        case (reply_sel_q)
            RSEL_STATUS: reply_mux = status_byte(cmd_count_q, err_flag_q,
                                                 beep_out_q, |key_latch_q);
            RSEL_VER:    reply_mux = CPLD_VER;
            RSEL_KEYS:   reply_mux = 8'(key_latch_q);
            default:     reply_mux = led_reg_q;
        endcase
        // Frozen while the receiver is shifting a frame out (sel low).
        reply_data_d = sel_s2_q ? reply_mux : reply_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_s1_q     <= 1'b0;
            rdy_s2_q     <= 1'b0;
            rdy_s3_q     <= 1'b0;
            sel_s1_q     <= 1'b0;
            sel_s2_q     <= 1'b0;
            led_reg_q    <= 8'h00;
            duty_q       <= 8'h00;
            beep_cnt_q   <= 24'd0;
            reply_sel_q  <= RSEL_STATUS;
            key_latch_q  <= '0;
            err_flag_q   <= 1'b0;
            cmd_count_q  <= 4'd0;
            pre_q        <= 8'd0;
            pwm_cnt_q    <= 8'd0;
            led_out_q    <= 8'h00;
            beep_out_q   <= 1'b0;
            cmd_strb_q   <= 1'b0;
            reply_data_q <= 8'h01;
        end else begin
            rdy_s1_q     <= rdy_s1_d;
            rdy_s2_q     <= rdy_s2_d;
            rdy_s3_q     <= rdy_s3_d;
            sel_s1_q     <= sel_s1_d;
            sel_s2_q     <= sel_s2_d;
            led_reg_q    <= led_reg_d;
            duty_q       <= duty_d;
            beep_cnt_q   <= beep_cnt_d;
            reply_sel_q  <= reply_sel_d;
            key_latch_q  <= key_latch_d;
            err_flag_q   <= err_flag_d;
            cmd_count_q  <= cmd_count_d;
            pre_q        <= pre_d;
            pwm_cnt_q    <= pwm_cnt_d;
            led_out_q    <= led_out_d;
            beep_out_q   <= beep_out_d;
            cmd_strb_q   <= cmd_strb_d;
            reply_data_q <= reply_data_d;
        end
    end

    assign replyData = reply_data_q;
    assign ledOut    = led_out_q;
    assign beepOut   = beep_out_q;
    assign cmdStrb   = cmd_strb_q;

endmodule
